direction_controller: RTL and testbench
=======================================

// Module: direction_controller
// PURPOSE
//   Registered direction selector for the game datapath: samples four push-button
//   inputs (left/right/up/down) and holds a 3-bit encoded movement direction.
//   Sits between the raw button pins and the movement/position logic.
//   The output is held until a new valid press arrives or reset is asserted.
// PARAMETERS
//   SYNC_STAGES  2  flip-flop stages per button input for metastability sync (0 = inputs used directly)
// PORTS
//   clk        input   1  system clock, rising-edge active
//   rst_n      input   1  asynchronous reset, active low
//   l          input   1  left button, active high
//   r          input   1  right button, active high
//   u          input   1  up button, active high
//   d          input   1  down button, active high
//   direction  output  3  registered direction code (encoding below)
// BEHAVIOUR
//   - One clock (clk), asynchronous active-low reset (rst_n). All state is in the clk domain.
//   - Encoding: 3'b000 NONE, 3'b001 LEFT, 3'b010 RIGHT, 3'b011 UP, 3'b100 DOWN; 101-111 never driven.
//   - Reset: rst_n low -> direction = 3'b000 immediately, and all sync flops = 0.
//     On rst_n release, sampling resumes on the next rising clk.
//   - Sync: each of l,r,u,d passes through SYNC_STAGES flops; the synced vector is {ls,rs,us,ds}.
//   - Decision, on each rising clk using the synced vector:
//       exactly one bit high -> direction <= code of that button;
//       zero bits high       -> hold;
//       two or more high     -> hold (ambiguous press ignored, no priority).
//   - Latency: a single-button press stable for at least 1 cycle is reflected on direction
//     SYNC_STAGES+1 rising edges after it is first sampled (3 cycles by default).
//   - Press width: one clock period is sufficient; button release never clears direction.
//   - Once non-NONE, direction returns to NONE only via reset.
//   - Re-pressing the current direction: direction unchanged, no glitch.
//   - X/Z on inputs while rst_n is low has no effect. Inputs are assumed 0/1 after reset.
// CONFIGURATION
//   NO_REVERSE_EN defined:
//     - A valid single press opposite the current direction is ignored and direction holds.
//     - Opposite pairs are LEFT<->RIGHT and UP<->DOWN.
//     - From NONE every direction is accepted.
//     - Perpendicular changes are accepted normally.
//   NO_REVERSE_EN undefined: every valid single press is accepted, including reversals.
// TESTING
//   1 Assert rst_n=0 mid-run with direction=UP -> direction=000 asynchronously.
//     Release, no buttons pressed -> direction stays 000.
//   2 l=1 for one cycle, then all 0 -> direction=001 after SYNC_STAGES+1 edges and holds 001.
//   3 Presses l, r, u, d, each for one 20-time-unit clock period, in sequence
//     -> direction steps 001,010,011,100, each delayed by SYNC_STAGES+1 cycles.
//   4 Direction=011, then l=1 and d=1 together -> direction holds 011.
//   5 With NO_REVERSE_EN, direction=001, press r -> holds 001. Then press u -> 011.
//     Without NO_REVERSE_EN, the r press gives 010.
//   6 Set SYNC_STAGES=0, press d -> direction=100 on the first rising edge after the press.

Source files
------------

// File: rtl/direction_controller.sv
// -----------------------------------------------------------------------------
// direction_controller
//   Registered direction selector between the raw game push-buttons and the
//   movement/position logic. Each button is synchronised through SYNC_STAGES
//   flops. A clean single press updates the held 3-bit direction code.
//   Ambiguous presses (two or more buttons) and idle inputs leave it unchanged.
//   Once a direction has been taken, only reset returns the output to NONE.
//
//   Optional feature macro: NO_REVERSE_EN
//     When defined, a press opposite the current direction is ignored.
//     The opposite pairs are LEFT<->RIGHT and UP<->DOWN.
//     When undefined, every valid single press is accepted.
// -----------------------------------------------------------------------------
module direction_controller #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       l,
  input  logic       r,
  input  logic       u,
  input  logic       d,
  output logic [2:0] direction
);

  typedef enum logic [2:0] {
    DIR_NONE  = 3'b000,
    DIR_LEFT  = 3'b001,
    DIR_RIGHT = 3'b010,
    DIR_UP    = 3'b011,
    DIR_DOWN  = 3'b100
  } dir_t;

  dir_t       dir_q;
  dir_t       dir_d;
  dir_t       pressed;
  logic       pressed_valid;
  logic [3:0] raw;
  logic [3:0] synced;

  // Button vector ordering used throughout: {left, right, up, down}.
  assign raw = {l, r, u, d};

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      // No synchroniser: the buttons feed the decision logic directly.
      assign synced = raw;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][3:0] sync_q;

      // Metastability chain: stage 0 samples the pins, later stages shift it along.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          // NOTE: the sync chain is cleared on reset too, so a press caught
          // mid-pipeline when reset hits can never surface after release.
          sync_q <= '0;
        end else begin
          // NOTE: non-blocking assignments make every stage take the value its
          // predecessor held before this edge; blocking ones would collapse the chain.
          sync_q[0] <= raw;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign synced = sync_q[SYNC_STAGES-1];
    end
  endgenerate

`ifdef NO_REVERSE_EN
  // True when the candidate direction is a reversal of the current one.
  function automatic logic is_opposite(input dir_t cur, input dir_t cand);
    is_opposite = ((cur == DIR_LEFT)  && (cand == DIR_RIGHT)) ||
                  ((cur == DIR_RIGHT) && (cand == DIR_LEFT))  ||
                  ((cur == DIR_UP)    && (cand == DIR_DOWN))  ||
                  ((cur == DIR_DOWN)  && (cand == DIR_UP));
  endfunction
`endif

  // Decode the synced vector; only a one-hot pattern is a valid press.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    pressed       = DIR_NONE;
    pressed_valid = 1'b0;
    case (synced)
      4'b1000: begin pressed = DIR_LEFT;  pressed_valid = 1'b1; end
      4'b0100: begin pressed = DIR_RIGHT; pressed_valid = 1'b1; end
      4'b0010: begin pressed = DIR_UP;    pressed_valid = 1'b1; end
      4'b0001: begin pressed = DIR_DOWN;  pressed_valid = 1'b1; end
      default: begin pressed = DIR_NONE;  pressed_valid = 1'b0; end
    endcase
  end

  // Next direction: hold unless a valid press is allowed to replace it.
  always_comb begin
    dir_d = dir_q;
    if (pressed_valid) begin
`ifdef NO_REVERSE_EN
      if (!is_opposite(dir_q, pressed)) begin
        dir_d = pressed;
      end
`else
      dir_d = pressed;
`endif
    end
  end

  // Direction register: cleared asynchronously, otherwise updated every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q <= DIR_NONE;
    end else begin
      dir_q <= dir_d;
    end
  end

  assign direction = dir_q;

endmodule

// File: tb/tb_direction_controller.sv
// -----------------------------------------------------------------------------
// tb_direction_controller
//   Directed bench for direction_controller. The main instance uses the
//   default two-stage synchroniser. A second instance has SYNC_STAGES = 0 and
//   covers the direct-input latency. Expectations that depend on NO_REVERSE_EN
//   follow the same macro.
//   Inputs change on the falling edge, and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_direction_controller;

  localparam logic [2:0] NONE  = 3'b000;
  localparam logic [2:0] LEFT  = 3'b001;
  localparam logic [2:0] RIGHT = 3'b010;
  localparam logic [2:0] UP    = 3'b011;
  localparam logic [2:0] DOWN  = 3'b100;

  logic       clk;
  logic       rst_n;
  logic       l, r, u, d;
  logic [2:0] direction;
  logic [2:0] direction0;

  int n_checks;
  int n_fail;

  direction_controller #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .l         (l),
    .r         (r),
    .u         (u),
    .d         (d),
    .direction (direction)
  );

  direction_controller #(.SYNC_STAGES(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .l         (l),
    .r         (r),
    .u         (u),
    .d         (d),
    .direction (direction0)
  );

  // 20-unit clock period.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Synchronous-looking reset pulse applied between edges.
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    {l, r, u, d} = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one button vector for one clock period and return to idle.
  // On return, one rising edge has sampled the press.
  task automatic press(input logic [3:0] btn);
    @(negedge clk);
    {l, r, u, d} = btn;
    @(negedge clk);
    {l, r, u, d} = 4'b0000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {l, r, u, d} = 4'bxxxx;
    #5;
    n_checks++;
    if (direction !== NONE) begin
      n_fail++;
      $display("FAIL reset_initial: got %b expected %b", direction, NONE);
    end
    n_checks++;
    if (direction0 !== NONE) begin
      n_fail++;
      $display("FAIL reset_initial_nosync: got %b expected %b", direction0, NONE);
    end
    // X on the buttons while reset is held must not disturb anything.
    repeat (3) @(negedge clk);
    n_checks++;
    if (direction !== NONE) begin
      n_fail++;
      $display("FAIL reset_x_inputs: got %b expected %b", direction, NONE);
    end
    {l, r, u, d} = 4'b0000;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (direction !== NONE) begin
      n_fail++;
      $display("FAIL reset_idle_after_release: got %b expected %b", direction, NONE);
    end
  endtask

  task automatic test_async_reset_mid();
    apply_reset();
    press(4'b0010);
    repeat (2) @(negedge clk);
    n_checks++;
    if (direction !== UP) begin
      n_fail++;
      $display("FAIL async_setup_up: got %b expected %b", direction, UP);
    end
    // Put a left press into the synchroniser, then reset mid-cycle.
    press(4'b1000);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (direction !== NONE) begin
      n_fail++;
      $display("FAIL async_reset_immediate: got %b expected %b", direction, NONE);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (direction !== NONE) begin
        n_fail++;
        $display("FAIL async_reset_sync_flushed cycle %0d: got %b expected %b", i, direction, NONE);
      end
    end
  endtask

  task automatic test_single_press();
    apply_reset();
    press(4'b1000);                 // after rising edge 1
    n_checks++;
    if (direction !== NONE) begin
      n_fail++;
      $display("FAIL single_edge1: got %b expected %b", direction, NONE);
    end
    @(negedge clk);                 // after rising edge 2
    n_checks++;
    if (direction !== NONE) begin
      n_fail++;
      $display("FAIL single_edge2: got %b expected %b", direction, NONE);
    end
    @(negedge clk);                 // after rising edge 3
    n_checks++;
    if (direction !== LEFT) begin
      n_fail++;
      $display("FAIL single_edge3: got %b expected %b", direction, LEFT);
    end
    // Releasing the button never clears the direction.
    repeat (3) @(negedge clk);
    n_checks++;
    if (direction !== LEFT) begin
      n_fail++;
      $display("FAIL single_hold: got %b expected %b", direction, LEFT);
    end
  endtask

  task automatic test_sequence();
    logic [2:0] exp [4];
    exp[0] = LEFT;
`ifdef NO_REVERSE_EN
    exp[1] = LEFT;                  // right reverses left
    exp[2] = UP;
    exp[3] = UP;                    // down reverses up
`else
    exp[1] = RIGHT;
    exp[2] = UP;
    exp[3] = DOWN;
`endif
    apply_reset();
    @(negedge clk); {l, r, u, d} = 4'b1000;
    @(negedge clk); {l, r, u, d} = 4'b0100;
    @(negedge clk); {l, r, u, d} = 4'b0010;
    n_checks++;
    if (direction !== NONE) begin
      n_fail++;
      $display("FAIL seq_before_first: got %b expected %b", direction, NONE);
    end
    @(negedge clk); {l, r, u, d} = 4'b0001;
    n_checks++;
    if (direction !== exp[0]) begin
      n_fail++;
      $display("FAIL seq_step0: got %b expected %b", direction, exp[0]);
    end
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      {l, r, u, d} = 4'b0000;
      n_checks++;
      if (direction !== exp[i]) begin
        n_fail++;
        $display("FAIL seq_step%0d: got %b expected %b", i, direction, exp[i]);
      end
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (direction !== exp[3]) begin
      n_fail++;
      $display("FAIL seq_hold: got %b expected %b", direction, exp[3]);
    end
  endtask

  task automatic test_ambiguous();
    logic [3:0] multi [3];
    multi[0] = 4'b1001;             // left + down
    multi[1] = 4'b1100;             // left + right
    multi[2] = 4'b1111;             // all four
    apply_reset();
    press(4'b0010);
    repeat (2) @(negedge clk);
    n_checks++;
    if (direction !== UP) begin
      n_fail++;
      $display("FAIL ambig_setup_up: got %b expected %b", direction, UP);
    end
    for (int k = 0; k < 3; k++) begin
      press(multi[k]);
      repeat (3) @(negedge clk);
      n_checks++;
      if (direction !== UP) begin
        n_fail++;
        $display("FAIL ambig_hold pattern %b: got %b expected %b", multi[k], direction, UP);
      end
    end
    // Re-pressing the current direction keeps the output steady every cycle.
    @(negedge clk); {l, r, u, d} = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (direction !== UP) begin
        n_fail++;
        $display("FAIL repress_steady cycle %0d: got %b expected %b", i, direction, UP);
      end
    end
    {l, r, u, d} = 4'b0000;
  endtask

  task automatic test_reverse();
    logic [2:0] exp_rev;
    logic [2:0] exp_down;
`ifdef NO_REVERSE_EN
    exp_rev  = LEFT;
    exp_down = UP;
`else
    exp_rev  = RIGHT;
    exp_down = DOWN;
`endif
    apply_reset();
    press(4'b1000);
    repeat (2) @(negedge clk);
    n_checks++;
    if (direction !== LEFT) begin
      n_fail++;
      $display("FAIL rev_setup_left: got %b expected %b", direction, LEFT);
    end
    press(4'b0100);
    repeat (2) @(negedge clk);
    n_checks++;
    if (direction !== exp_rev) begin
      n_fail++;
      $display("FAIL rev_right_press: got %b expected %b", direction, exp_rev);
    end
    press(4'b0010);
    repeat (2) @(negedge clk);
    n_checks++;
    if (direction !== UP) begin
      n_fail++;
      $display("FAIL rev_perpendicular_up: got %b expected %b", direction, UP);
    end
    press(4'b0001);
    repeat (2) @(negedge clk);
    n_checks++;
    if (direction !== exp_down) begin
      n_fail++;
      $display("FAIL rev_down_press: got %b expected %b", direction, exp_down);
    end
  endtask

  task automatic test_no_sync();
    apply_reset();
    @(negedge clk);
    {l, r, u, d} = 4'b0001;
    #1;
    n_checks++;
    if (direction0 !== NONE) begin
      n_fail++;
      $display("FAIL nosync_before_edge: got %b expected %b", direction0, NONE);
    end
    @(negedge clk);
    {l, r, u, d} = 4'b0000;
    n_checks++;
    if (direction0 !== DOWN) begin
      n_fail++;
      $display("FAIL nosync_first_edge: got %b expected %b", direction0, DOWN);
    end
    n_checks++;
    if (direction !== NONE) begin
      n_fail++;
      $display("FAIL nosync_synced_still_none: got %b expected %b", direction, NONE);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (direction0 !== DOWN) begin
      n_fail++;
      $display("FAIL nosync_hold: got %b expected %b", direction0, DOWN);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    {l, r, u, d} = 4'b0000;
    test_reset();
    test_async_reset_mid();
    test_single_press();
    test_sequence();
    test_ambiguous();
    test_reverse();
    test_no_sync();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
